// File: rtl/gfx_pkg.sv
// Shared definitions for the pixel writer: FSM states, bpp check and
// the default memory data width expressed as its log2.
package gfx_pkg;

  // Default memory data width is 2**GFX_LOG2_MDW bits.
  localparam int GFX_LOG2_MDW = 8;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    READ,
    WRITE,
    DONE
  } gfx_state_e;

  // Only power-of-two depths up to one 32-bit colour are supported; these
  // never straddle a memory word.
  function automatic logic gfx_bpp_ok(input logic [5:0] bpp);
    return (bpp == 6'd1) || (bpp == 6'd2) || (bpp == 6'd4) ||
           (bpp == 6'd8) || (bpp == 6'd16) || (bpp == 6'd32);
  endfunction

endpackage

// File: rtl/gfx_color_packer.sv
// Colour-to-memory packer: places a masked colour at bit offset mb inside a
// memory word. In read-modify-write mode the surrounding bits come from the
// word read back and every byte lane is written; otherwise only the lanes
// covered by the pixel are enabled.
module gfx_color_packer #(
  parameter int MDW = 256
) (
  input  logic             rmw_i,
  input  logic [7:0]       mb_i,
  input  logic [5:0]       bpp_i,
  input  logic [31:0]      color_i,
  input  logic [MDW-1:0]   word_i,
  output logic [MDW-1:0]   dat_o,
  output logic [MDW/8-1:0] sel_o
);

  logic [31:0]    cmask;
  logic [MDW-1:0] fmask;
  logic [MDW-1:0] field;

  // Build the pixel field mask and merge the colour into the word.
  always_comb begin
    cmask = '1;
    if (bpp_i < 6'd32) begin
      cmask = (32'd1 << bpp_i) - 32'd1;
    end
    fmask = MDW'(cmask) << mb_i;
    field = MDW'(color_i & cmask) << mb_i;
    if (rmw_i) begin
      dat_o = (word_i & ~fmask) | field;
    end else begin
      dat_o = field;
    end
  end

  // A lane is enabled when the pixel touches it, or always during RMW.
  for (genvar gi = 0; gi < MDW / 8; gi++) begin : g_lane
    assign sel_o[gi] = rmw_i | (|fmask[8*gi +: 8]);
  end

endmodule

// File: rtl/gfx_pixel_addr.sv
// Pixel address generator: turns (x, y) on a surface of the given width and
// depth into a bus word address plus the bit offset inside that word.
module gfx_pixel_addr #(
  parameter int MDW = 256,
  parameter int AW  = 32,
  parameter int PW  = 16
) (
  input  logic [AW-1:0] base_i,
  input  logic [PW-1:0] x_i,
  input  logic [PW-1:0] y_i,
  input  logic [PW-1:0] width_i,
  input  logic [5:0]    bpp_i,
  output logic [AW-1:0] adr_o,
  output logic [7:0]    mb_o
);

  localparam int LOG2_MDW = $clog2(MDW);

  logic [47:0] bitaddr;

  // Linear bit address, then split into word byte-address and in-word offset.
  always_comb begin
    bitaddr = (48'(y_i) * 48'(width_i) + 48'(x_i)) * 48'(bpp_i);
    adr_o   = base_i + AW'(64'(bitaddr >> LOG2_MDW) << (LOG2_MDW - 3));
    mb_o    = 8'(bitaddr & 48'(MDW - 1));
  end

endmodule

// File: rtl/gfx_pixel_writer.sv
// Pixel writer: accepts one (x, y, colour) request, computes its memory
// location and performs a plain write (bpp >= 8) or a read-modify-write
// (bpp < 8) on the memory bus, then pulses done_o.
// Optional clipping rectangle is enabled with `define GFX_PIXEL_CLIP_EN.
module gfx_pixel_writer
  import gfx_pkg::*;
#(
  parameter int MDW = 2 ** GFX_LOG2_MDW,
  parameter int AW  = 32,
  parameter int PW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [PW-1:0]    pix_x_i,
  input  logic [PW-1:0]    pix_y_i,
  input  logic [31:0]      pix_color_i,
  input  logic [AW-1:0]    tgt_base_i,
  input  logic [PW-1:0]    tgt_width_i,
  input  logic [5:0]       bpp_i,
`ifdef GFX_PIXEL_CLIP_EN
  input  logic [PW-1:0]    clip_x0_i,
  input  logic [PW-1:0]    clip_y0_i,
  input  logic [PW-1:0]    clip_x1_i,
  input  logic [PW-1:0]    clip_y1_i,
  output logic             clipped_o,
`endif
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [AW-1:0]    m_adr_o,
  output logic [MDW/8-1:0] m_sel_o,
  output logic [MDW-1:0]   m_dat_o,
  input  logic [MDW-1:0]   m_dat_i,
  input  logic             m_ack_i,
  output logic             done_o,
  output logic             err_o
);

  gfx_state_e state_q, state_d;

  logic [PW-1:0]    x_q, x_d, y_q, y_d, width_q, width_d;
  logic [31:0]      color_q, color_d;
  logic [AW-1:0]    base_q, base_d;
  logic [5:0]       bpp_q, bpp_d;
  logic [MDW-1:0]   rmw_word_q, rmw_word_d;
  logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [MDW/8-1:0] sel_q, sel_d;
  logic [MDW-1:0]   dat_q, dat_d;
  logic             done_q, done_d, err_q, err_d;

  logic [AW-1:0]    calc_adr;
  logic [7:0]       calc_mb;
  logic [MDW-1:0]   pack_dat;
  logic [MDW/8-1:0] pack_sel;
  logic             rmw_mode;

`ifdef GFX_PIXEL_CLIP_EN
  logic [PW-1:0] cx0_q, cx0_d, cy0_q, cy0_d, cx1_q, cx1_d, cy1_q, cy1_d;
  logic          clipped_q, clipped_d;
  logic          clip_out;

  // Inclusive clip rectangle test on the latched coordinates.
  always_comb begin
    clip_out = (x_q < cx0_q) || (x_q > cx1_q) || (y_q < cy0_q) || (y_q > cy1_q);
  end

  assign clipped_o = clipped_q;
`endif

  assign rmw_mode = (bpp_q < 6'd8);

  gfx_pixel_addr #(
    .MDW(MDW),
    .AW (AW),
    .PW (PW)
  ) u_addr (
    .base_i (base_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .width_i(width_q),
    .bpp_i  (bpp_q),
    .adr_o  (calc_adr),
    .mb_o   (calc_mb)
  );

  gfx_color_packer #(
    .MDW(MDW)
  ) u_pack (
    .rmw_i  (rmw_mode),
    .mb_i   (calc_mb),
    .bpp_i  (bpp_q),
    .color_i(color_q),
    .word_i (rmw_word_d),
    .dat_o  (pack_dat),
    .sel_o  (pack_sel)
  );

  // The read data is fed straight to the packer in the ack cycle so the
  // write data is ready in the very next clock.
  always_comb begin
    rmw_word_d = rmw_word_q;
    if (state_q == READ && m_ack_i) begin
      rmw_word_d = m_dat_i;
    end
  end

  // Next-state and next-output logic; bus outputs are loaded one clock ahead.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    width_d   = width_q;
    color_d   = color_q;
    base_d    = base_q;
    bpp_d     = bpp_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef GFX_PIXEL_CLIP_EN
    cx0_d     = cx0_q;
    cy0_d     = cy0_q;
    cx1_d     = cx1_q;
    cy1_d     = cy1_q;
    clipped_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pix_valid_i) begin
          x_d     = pix_x_i;
          y_d     = pix_y_i;
          width_d = tgt_width_i;
          color_d = pix_color_i;
          base_d  = tgt_base_i;
          bpp_d   = bpp_i;
`ifdef GFX_PIXEL_CLIP_EN
          cx0_d   = clip_x0_i;
          cy0_d   = clip_y0_i;
          cx1_d   = clip_x1_i;
          cy1_d   = clip_y1_i;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        if (!gfx_bpp_ok(bpp_q)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
`ifdef GFX_PIXEL_CLIP_EN
        else if (clip_out) begin
          clipped_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end
`endif
        else if (rmw_mode) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = calc_adr;
          sel_d   = '1;
          dat_d   = '0;
          state_d = READ;
        end else begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = calc_adr;
          sel_d   = pack_sel;
          dat_d   = pack_dat;
          state_d = WRITE;
        end
      end
      READ: begin
        if (m_ack_i) begin
          we_d    = 1'b1;
          sel_d   = pack_sel;
          dat_d   = pack_dat;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (m_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = '0;
          sel_d   = '0;
          dat_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request and bus registers; reset drops the bus at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      width_q    <= '0;
      color_q    <= '0;
      base_q     <= '0;
      bpp_q      <= '0;
      rmw_word_q <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef GFX_PIXEL_CLIP_EN
      cx0_q      <= '0;
      cy0_q      <= '0;
      cx1_q      <= '0;
      cy1_q      <= '0;
      clipped_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      width_q    <= width_d;
      color_q    <= color_d;
      base_q     <= base_d;
      bpp_q      <= bpp_d;
      rmw_word_q <= rmw_word_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef GFX_PIXEL_CLIP_EN
      cx0_q      <= cx0_d;
      cy0_q      <= cy0_d;
      cx1_q      <= cx1_d;
      cy1_q      <= cy1_d;
      clipped_q  <= clipped_d;
`endif
    end
  end

  assign pix_ready_o = (state_q == IDLE);
  assign m_cyc_o     = cyc_q;
  assign m_stb_o     = stb_q;
  assign m_we_o      = we_q;
  assign m_adr_o     = adr_q;
  assign m_sel_o     = sel_q;
  assign m_dat_o     = dat_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_gfx_pixel_writer.sv
// Directed bench for gfx_pixel_writer (MDW=256): plain writes, RMW, bad
// depth, long ack stall with back-to-back request, reset mid-read and,
// when GFX_PIXEL_CLIP_EN is defined, clipping.
module tb_gfx_pixel_writer;

  localparam int MDW = 256;
  localparam int AW  = 32;
  localparam int PW  = 16;
  localparam int SW  = MDW / 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pix_valid, pix_ready;
  logic [PW-1:0]  pix_x, pix_y, tgt_width;
  logic [31:0]    pix_color;
  logic [AW-1:0]  tgt_base;
  logic [5:0]     bpp;
  logic           m_cyc, m_stb, m_we, m_ack;
  logic [AW-1:0]  m_adr;
  logic [SW-1:0]  m_sel;
  logic [MDW-1:0] m_dat_o, m_dat_i;
  logic           done, err;
`ifdef GFX_PIXEL_CLIP_EN
  logic [PW-1:0]  clip_x0, clip_y0, clip_x1, clip_y1;
  logic           clipped;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pixel_no = 0;
  logic [MDW-1:0] e;

  always #5 clk = ~clk;

  gfx_pixel_writer #(.MDW(MDW), .AW(AW), .PW(PW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready),
    .pix_x_i    (pix_x),
    .pix_y_i    (pix_y),
    .pix_color_i(pix_color),
    .tgt_base_i (tgt_base),
    .tgt_width_i(tgt_width),
    .bpp_i      (bpp),
`ifdef GFX_PIXEL_CLIP_EN
    .clip_x0_i  (clip_x0),
    .clip_y0_i  (clip_y0),
    .clip_x1_i  (clip_x1),
    .clip_y1_i  (clip_y1),
    .clipped_o  (clipped),
`endif
    .m_cyc_o    (m_cyc),
    .m_stb_o    (m_stb),
    .m_we_o     (m_we),
    .m_adr_o    (m_adr),
    .m_sel_o    (m_sel),
    .m_dat_o    (m_dat_o),
    .m_dat_i    (m_dat_i),
    .m_ack_i    (m_ack),
    .done_o     (done),
    .err_o      (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [PW-1:0] x, input logic [PW-1:0] y, input logic [31:0] c,
                      input logic [AW-1:0] b, input logic [PW-1:0] w, input logic [5:0] d);
    pix_x = x; pix_y = y; pix_color = c; tgt_base = b; tgt_width = w; bpp = d;
    pix_valid = 1'b1;
    pixel_no++;
    $display("pixel %0d: x=%0d y=%0d colour=%h base=%h width=%0d bpp=%0d",
             pixel_no, x, y, c, b, w, d);
  endtask

  initial begin
    pix_valid = 0; pix_x = 0; pix_y = 0; pix_color = 0; tgt_base = 0;
    tgt_width = 0; bpp = 0; m_ack = 0; m_dat_i = '0;
`ifdef GFX_PIXEL_CLIP_EN
    clip_x0 = 0; clip_y0 = 0; clip_x1 = 16'hFFFF; clip_y1 = 16'hFFFF;
`endif
    step(); step();
    chk("rst_ready", pix_ready, 1);
    chk("rst_cyc_stb_we", {m_cyc, m_stb, m_we}, 0);
    chk("rst_adr_sel", {m_adr, m_sel}, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_done_err", {done, err}, 0);
    rst_n = 1'b1;
    step();

    // stray ack while idle
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("idle_ack_ready", pix_ready, 1);
    chk("idle_ack_cyc", m_cyc, 0);

    // 32 bpp plain write
    send(10, 2, 32'hAABBCCDD, 32'h1000, 640, 32);
    step();
    pix_valid = 0; pix_x = 16'h7777; pix_color = 0; bpp = 6'd24;
    chk("t1_calc_ready", pix_ready, 0);
    chk("t1_calc_cyc", m_cyc, 0);
    step();
    e = '0; e[95:64] = 32'hAABBCCDD;
    chk("t1_cyc_stb_we", {m_cyc, m_stb, m_we}, 3'b111);
    chk("t1_adr", m_adr, 32'h2420);
    chk("t1_sel", m_sel, 32'h0000_0F00);
    chk("t1_dat", m_dat_o, e);
    step();
    chk("t1_hold_adr", m_adr, 32'h2420);
    chk("t1_no_done_yet", done, 0);
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("t1_done_err", {done, err}, 2'b10);
    chk("t1_bus_released", {m_cyc, m_stb, m_we}, 0);
    chk("t1_adr_cleared", m_adr, 0);
    chk("t1_ready_in_done", pix_ready, 0);
    step();
    chk("t1_ready_back", pix_ready, 1);
    chk("t1_done_pulse", done, 0);

    // 4 bpp read-modify-write
    send(3, 0, 32'h0000000F, 32'h1000, 640, 4);
    step(); pix_valid = 0;
    step();
    chk("t2_read_cyc_stb_we", {m_cyc, m_stb, m_we}, 3'b110);
    chk("t2_read_adr", m_adr, 32'h1000);
    chk("t2_read_sel", m_sel, 32'hFFFF_FFFF);
    m_dat_i = {32{8'h55}}; m_ack = 1'b1; step(); m_ack = 1'b0; m_dat_i = '0;
    e = {32{8'h55}}; e[15:12] = 4'hF;
    chk("t2_write_cyc_stb_we", {m_cyc, m_stb, m_we}, 3'b111);
    chk("t2_write_adr", m_adr, 32'h1000);
    chk("t2_write_sel", m_sel, 32'hFFFF_FFFF);
    chk("t2_write_dat", m_dat_o, e);
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("t2_done_err", {done, err}, 2'b10);
    step();
    chk("t2_ready_back", pix_ready, 1);

    // 2 bpp RMW with colour bits above bpp masked
    send(5, 1, 32'hFFFFFFFE, 32'h2000, 100, 2);
    step(); pix_valid = 0;
    step();
    chk("t2b_read_adr", m_adr, 32'h2000);
    m_dat_i = '0; m_ack = 1'b1; step(); m_ack = 1'b0;
    e = '0; e[211:210] = 2'b10;
    chk("t2b_write_dat", m_dat_o, e);
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("t2b_done", done, 1);
    step();

    // unsupported depth dropped
    send(1, 1, 32'h12345678, 32'h3000, 10, 24);
    step(); pix_valid = 0;
    chk("t3_calc_cyc", m_cyc, 0);
    step();
    chk("t3_done_err", {done, err}, 2'b11);
    chk("t3_no_bus", {m_cyc, m_stb, m_we}, 0);
    chk("t3_ready_low", pix_ready, 0);
    step();
    chk("t3_ready_back", pix_ready, 1);
    chk("t3_pulse_end", {done, err}, 0);

    // 16 bpp, width 0, ack held off 7 cycles, second request waiting
    send(1, 1, 32'h12345678, 32'h4000, 0, 16);
    step();
    pix_x = 50;
    chk("t4_calc_ready", pix_ready, 0);
    step();
    e = '0; e[31:16] = 16'h5678;
    chk("t4_adr", m_adr, 32'h4000);
    chk("t4_sel", m_sel, 32'h0000_000C);
    chk("t4_dat", m_dat_o, e);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t4_hold_adr", m_adr, 32'h4000);
      chk("t4_hold_sel", m_sel, 32'h0000_000C);
      chk("t4_hold_dat", m_dat_o, e);
      chk("t4_hold_cyc_ready", {m_cyc, pix_ready}, 2'b10);
    end
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_ready_in_done", pix_ready, 0);
    step();
    chk("t4_ready_back", pix_ready, 1);
    pixel_no++;
    $display("pixel %0d: queued x=%0d y=%0d bpp=16 width=0", pixel_no, pix_x, pix_y);
    step(); pix_valid = 0;
    chk("t4b_calc_ready", pix_ready, 0);
    step();
    e = '0; e[47:32] = 16'h5678;
    chk("t4b_adr", m_adr, 32'h4060);
    chk("t4b_sel", m_sel, 32'h0000_0030);
    chk("t4b_dat", m_dat_o, e);
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("t4b_done", done, 1);
    step();

    // reset asserted during the read phase
    send(0, 0, 32'h1, 32'h8000, 10, 1);
    step(); pix_valid = 0;
    step();
    chk("t5_read_cyc", m_cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_cyc_stb", {m_cyc, m_stb}, 0);
    chk("t5_async_ready", pix_ready, 1);
    step();
    chk("t5_no_done", done, 0);
    rst_n = 1'b1;
    step();
    chk("t5_no_done_after", done, 0);
    send(7, 0, 32'h000000A5, 32'h8000, 10, 8);
    step(); pix_valid = 0;
    step();
    e = '0; e[63:56] = 8'hA5;
    chk("t5b_cyc_stb_we", {m_cyc, m_stb, m_we}, 3'b111);
    chk("t5b_adr", m_adr, 32'h8000);
    chk("t5b_sel", m_sel, 32'h0000_0080);
    chk("t5b_dat", m_dat_o, e);
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("t5b_done_err", {done, err}, 2'b10);
    step();

`ifdef GFX_PIXEL_CLIP_EN
    // clipping rectangle (0,0)-(99,99)
    clip_x0 = 0; clip_y0 = 0; clip_x1 = 99; clip_y1 = 99;
    send(100, 5, 32'h11223344, 32'h0, 640, 32);
    step(); pix_valid = 0;
    step();
    chk("t6_clip_done", {done, clipped, err}, 3'b110);
    chk("t6_clip_no_bus", m_cyc, 0);
    step();
    chk("t6_ready_back", pix_ready, 1);
    send(99, 99, 32'h11223344, 32'h0, 640, 32);
    step(); pix_valid = 0;
    step();
    e = '0; e[127:96] = 32'h11223344;
    chk("t6b_adr", m_adr, 32'h0003_DF80);
    chk("t6b_sel", m_sel, 32'h0000_F000);
    chk("t6b_dat", m_dat_o, e);
    m_ack = 1'b1; step(); m_ack = 1'b0;
    chk("t6b_done_clipped", {done, clipped}, 2'b10);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
